// File: rtl/btb_write_sched.sv
// btb_write_sched: arbitrates the single BTB write port between queued
// decode-stage corrections and a full-table invalidate sweep, and gates
// fetch prediction while the sweep runs.
// Optional build macro BTB_SCHED_STATS_EN adds saturating activity counters;
// without it the stat_* ports are tied to zero.
module btb_write_sched #(
  parameter int IDX_W      = 8,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              upd_valid,
  input  logic              upd_inval,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [ADDR_W-1:0] upd_target,
  output logic              upd_ready,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic              flush_done,
  output logic              pred_en,
  output logic              upd_ovf,
  output logic              btb_we,
  output logic [IDX_W-1:0]  btb_idx,
  output logic [ADDR_W:0]   btb_wdata,
  output logic [15:0]       stat_installs,
  output logic [15:0]       stat_invals,
  output logic [7:0]        stat_flushes
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = IDX_W + ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sweep_q, sweep_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [ENT_W-1:0]   entry_in;
  logic [ENT_W-1:0]   head;
  logic               push;
  logic               pop;
  logic               discard;
  logic               unused_pc_bits;

  // Only the index bits of the PC select a BTB entry.
  assign unused_pc_bits = ^{upd_pc[ADDR_W-1:IDX_W+2], upd_pc[1:0]};

  assign upd_ready  = (cnt_q != CNT_W'(FIFO_DEPTH));
  assign push       = upd_valid & upd_ready;
  assign entry_in   = {upd_pc[IDX_W+1:2],
                       upd_inval ? {(ADDR_W+1){1'b0}} : {1'b1, upd_target}};
  assign head       = fifo_mem[rd_ptr_q];
  assign flush_busy = (state_q != S_IDLE);
  assign pred_en    = ~flush_busy;

  // Next-state, write-port mux and FIFO pop/discard decisions.
  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    btb_we     = 1'b0;
    btb_idx    = '0;
    btb_wdata  = '0;
    flush_done = 1'b0;
    pop        = 1'b0;
    discard    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush_req) begin
          // Queued corrections predate the flush and are dropped; the
          // sweep owns the write port from the next cycle.
          state_d = S_FLUSH;
          sweep_d = '0;
          discard = 1'b1;
        end else if (cnt_q != '0) begin
          btb_we    = 1'b1;
          btb_idx   = head[ENT_W-1 -: IDX_W];
          btb_wdata = head[ADDR_W:0];
          pop       = 1'b1;
        end
      end
      S_FLUSH: begin
        btb_we  = 1'b1;
        btb_idx = sweep_q;
        sweep_d = sweep_q + 1'b1;
        if (&sweep_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        flush_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and sweep counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      upd_ovf  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(push);
      if (discard) begin
        // Everything already queued is skipped; a same-cycle push survives.
        rd_ptr_q <= wr_ptr_q;
        cnt_q    <= CNT_W'(push);
      end else begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
        cnt_q    <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
      if (upd_valid && !upd_ready) begin
        upd_ovf <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are only meaningful under the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= entry_in;
    end
  end

`ifdef BTB_SCHED_STATS_EN
  // Saturating activity counters for queued writes and completed sweeps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_installs <= '0;
      stat_invals   <= '0;
      stat_flushes  <= '0;
    end else begin
      if (pop && head[ADDR_W] && (stat_installs != '1)) begin
        stat_installs <= stat_installs + 1'b1;
      end
      if (pop && !head[ADDR_W] && (stat_invals != '1)) begin
        stat_invals <= stat_invals + 1'b1;
      end
      if ((state_q == S_DONE) && (stat_flushes != '1)) begin
        stat_flushes <= stat_flushes + 1'b1;
      end
    end
  end
`else
  assign stat_installs = '0;
  assign stat_invals   = '0;
  assign stat_flushes  = '0;
`endif

endmodule

// File: tb/tb_btb_write_sched.sv
// Directed bench for btb_write_sched: stimulus queues the expected BTB
// writes, a negedge monitor pops and compares them as the DUT writes.
module tb_btb_write_sched;

  logic        clk;
  logic        rst_n;
  logic        upd_valid;
  logic        upd_inval;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_ready;
  logic        flush_req;
  logic        flush_busy;
  logic        flush_done;
  logic        pred_en;
  logic        upd_ovf;
  logic        btb_we;
  logic [7:0]  btb_idx;
  logic [32:0] btb_wdata;
  logic [15:0] stat_installs;
  logic [15:0] stat_invals;
  logic [7:0]  stat_flushes;

  typedef struct packed {
    logic [7:0]  idx;
    logic [32:0] wd;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks   = 0;
  int  errors   = 0;
  int  exp_done = 0;
  int  act_done = 0;

  btb_write_sched #(.IDX_W(8), .ADDR_W(32), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .upd_valid     (upd_valid),
    .upd_inval     (upd_inval),
    .upd_pc        (upd_pc),
    .upd_target    (upd_target),
    .upd_ready     (upd_ready),
    .flush_req     (flush_req),
    .flush_busy    (flush_busy),
    .flush_done    (flush_done),
    .pred_en       (pred_en),
    .upd_ovf       (upd_ovf),
    .btb_we        (btb_we),
    .btb_idx       (btb_idx),
    .btb_wdata     (btb_wdata),
    .stat_installs (stat_installs),
    .stat_invals   (stat_invals),
    .stat_flushes  (stat_flushes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] idx, input logic [32:0] wd);
    exp_q.push_back(wr_t'({idx, wd}));
  endtask

  task automatic exp_sweep();
    for (int i = 0; i < 256; i++) push_exp(i[7:0], 33'h0);
    exp_done++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n < 600) begin
      @(negedge clk);
      if (flush_done) break;
      n++;
    end
    chk("flush_done_seen", flush_done, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},    btb_we, 0);
    chk({tag, "_idx"},   btb_idx, 0);
    chk({tag, "_wdata"}, btb_wdata, 0);
    chk({tag, "_busy"},  flush_busy, 0);
    chk({tag, "_done"},  flush_done, 0);
    chk({tag, "_pred"},  pred_en, 1);
    chk({tag, "_ready"}, upd_ready, 1);
    chk({tag, "_ovf"},   upd_ovf, 0);
  endtask

  // Scoreboard monitor: every BTB write must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (btb_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got idx %0h wdata %0h, expected no write",
                   btb_idx, btb_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("write_idx", btb_idx, mon_e.idx);
          chk("write_data", btb_wdata, mon_e.wd);
        end
      end
      if (flush_done) begin
        act_done++;
        chk("done_we", btb_we, 0);
        chk("done_busy", flush_busy, 1);
        chk("done_pred", pred_en, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    upd_valid  = 1'b0;
    upd_inval  = 1'b0;
    upd_pc     = 32'h0;
    upd_target = 32'h0;
    flush_req  = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();

    // Single install: one cycle of latency, then idle.
    upd_valid  = 1'b1;
    upd_pc     = 32'h0040_0010;
    upd_target = 32'h0040_0100;
    push_exp(8'h04, 33'h1_0040_0100);
    cyc();
    upd_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("single_we_off", btb_we, 0);
    cyc();

    // Five back-to-back requests, one of them an invalidate.
    for (int k = 0; k < 5; k++) begin
      upd_valid  = 1'b1;
      upd_inval  = (k == 2);
      upd_pc     = 32'h0000_1000 + 32'((k + 1) * 4);
      upd_target = 32'hA000_0000 + 32'(k);
      if (k == 2) push_exp(8'(k + 1), 33'h0);
      else        push_exp(8'(k + 1), {1'b1, 32'hA000_0000 + 32'(k)});
      @(negedge clk);
      chk("b2b_ready", upd_ready, 1);
      cyc();
    end
    upd_valid = 1'b0;
    upd_inval = 1'b0;
    cyc();
    cyc();
    chk("b2b_ovf", upd_ovf, 0);

    // Flush with a stale entry queued and a same-cycle push.
    upd_valid  = 1'b1;
    upd_pc     = 32'h0000_0100;
    upd_target = 32'h1111_1111;
    cyc();
    upd_pc     = 32'h0000_0200;
    upd_target = 32'h2222_2222;
    flush_req  = 1'b1;
    exp_sweep();
    push_exp(8'h80, 33'h1_2222_2222);
    @(negedge clk);
    chk("flush_start_we", btb_we, 0);
    cyc();
    upd_valid = 1'b0;
    flush_req = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      chk("sweep_pred", pred_en, 0);
      chk("sweep_busy", flush_busy, 1);
      cyc();
    end
    @(negedge clk);
    chk("sweep_done_257", flush_done, 1);
    chk("sweep_done_pred", pred_en, 0);
    cyc();
    @(negedge clk);
    chk("after_done_pred", pred_en, 1);
    chk("after_done_we", btb_we, 1);
    cyc();
    cyc();

    // Overflow while the sweep holds off the FIFO.
    flush_req = 1'b1;
    exp_sweep();
    cyc();
    flush_req = 1'b0;
    for (int j = 0; j < 4; j++) begin
      upd_valid  = 1'b1;
      upd_inval  = (j == 2);
      upd_pc     = 32'h0000_0040 + 32'(j * 4);
      upd_target = 32'hB000_0000 + 32'(j);
      if (j == 2) push_exp(8'h10 + 8'(j), 33'h0);
      else        push_exp(8'h10 + 8'(j), {1'b1, 32'hB000_0000 + 32'(j)});
      @(negedge clk);
      chk("ovf_fill_ready", upd_ready, 1);
      cyc();
    end
    upd_inval  = 1'b0;
    upd_pc     = 32'h0000_0080;
    upd_target = 32'hC000_0000;
    @(negedge clk);
    chk("ovf_full_ready", upd_ready, 0);
    cyc();
    upd_valid = 1'b0;
    @(negedge clk);
    chk("ovf_sticky_set", upd_ovf, 1);
    chk("ovf_still_full", upd_ready, 0);
    wait_done();
    for (int i = 0; i < 6; i++) cyc();
    chk("ovf_sticky_hold", upd_ovf, 1);
    chk("ovf_drained_ready", upd_ready, 1);

    // flush_req held through DONE restarts immediately; queued entries go stale.
    flush_req = 1'b1;
    exp_sweep();
    exp_sweep();
    cyc();
    upd_valid  = 1'b1;
    upd_pc     = 32'h0000_00C0;
    upd_target = 32'hD000_0000;
    cyc();
    upd_pc     = 32'h0000_00C4;
    cyc();
    upd_valid = 1'b0;
    wait_done();
    @(negedge clk);
    chk("restart_idle_busy", flush_busy, 0);
    cyc();
    flush_req = 1'b0;
    @(negedge clk);
    chk("restart_busy", flush_busy, 1);
    wait_done();
    cyc();
    cyc();

    // Asynchronous reset in the middle of a sweep.
    flush_req = 1'b1;
    for (int i = 0; i < 100; i++) push_exp(i[7:0], 33'h0);
    cyc();
    flush_req = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("midsweep_idx", btb_idx, 8'd100);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", flush_busy, 0);
    chk("post_reset_we", btb_we, 0);
    cyc();
    upd_valid  = 1'b1;
    upd_inval  = 1'b1;
    upd_pc     = 32'h0000_0008;
    upd_target = 32'hDEAD_BEEF;
    push_exp(8'h02, 33'h0);
    cyc();
    upd_valid = 1'b0;
    upd_inval = 1'b0;
    cyc();
    cyc();

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("flush_done_count", act_done, exp_done);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_write_sched.md
Name: btb_write_sched

Overview:
- Scheduler for the single write port of the 256-entry branch target buffer (33-bit entries: valid + 32-bit target).
- Queues correction requests from the decode stage in a small FIFO.
- Runs a full-table invalidate sweep on request, and drives at most one BTB write per cycle.
- Gates fetch-stage prediction while a sweep is in progress.

Parameters:
- IDX_W, 8, BTB index width; table has 2^IDX_W entries, indexed by PC[IDX_W+1:2].
- ADDR_W, 32, PC/target width.
- FIFO_DEPTH, 4, update queue depth; power of two, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- upd_valid  in  1  decode-stage correction request this cycle.
- upd_inval  in  1  1 = clear entry (predicted taken, not taken); 0 = install target.
- upd_pc  in  ADDR_W  PC of the branch/jump in decode.
- upd_target  in  ADDR_W  branch or jump target; ignored when upd_inval=1.
- upd_ready  out  1  FIFO not full.
- flush_req  in  1  start full-table invalidate; level sampled each cycle.
- flush_busy  out  1  sweep in progress (FLUSH or DONE state).
- flush_done  out  1  one-cycle pulse at sweep completion.
- pred_en  out  1  fetch may use BTB hit; 0 while flush_busy.
- upd_ovf  out  1  sticky: request dropped because FIFO full.
- btb_we  out  1  BTB write enable; write occurs on the clk edge ending the cycle.
- btb_idx  out  IDX_W  BTB write index.
- btb_wdata  out  ADDR_W+1  {valid, target}.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty, state IDLE, sweep counter 0, upd_ovf=0.
  - Outputs: btb_we=0, btb_idx=0, btb_wdata=0, flush_busy=0, flush_done=0, pred_en=1, upd_ready=1.
  - BTB contents are not touched. Reset mid-sweep abandons the sweep; the table may be partially cleared.
- Enqueue:
  - Occurs when upd_valid && upd_ready.
  - Stores {upd_pc[IDX_W+1:2], upd_inval ? {1'b0, 0} : {1'b1, upd_target}}.
  - upd_ready depends only on the registered count; a push while full is dropped even if a pop occurs that cycle, and sets upd_ovf=1 until reset.
- btb_* outputs are combinational from state, FIFO head and sweep counter. All state is registered.
- IDLE:
  - FIFO non-empty: btb_we=1, idx/wdata = head entry; pop at the edge.
  - An entry pushed at edge N is written in cycle N+1, so one cycle of latency.
  - FIFO empty: btb_we=0.
  - Strict FIFO order; no coalescing of same-index entries, so the last write wins.
- IDLE → FLUSH when flush_req=1:
  - No FIFO write occurs in that cycle.
  - Entries in the FIFO at the start of that cycle are discarded as stale.
  - A push accepted in the same cycle is retained.
  - Sweep counter is cleared to 0.
- FLUSH:
  - Each cycle: btb_we=1, btb_idx=counter, btb_wdata=0; counter increments.
  - When counter = 2^IDX_W−1 the counter wraps to 0 and the state goes to DONE.
  - Duration is exactly 2^IDX_W cycles.
  - FIFO keeps accepting pushes but does not pop.
  - flush_req is ignored; there is no restart.
- DONE:
  - One cycle: flush_done=1, btb_we=0, flush_busy=1, pred_en=0.
  - Next state is IDLE; flush_req in DONE is ignored.
  - flush_req still high in the first IDLE cycle starts a new sweep.
- flush_busy = (state≠IDLE); pred_en = ~flush_busy.

Optional Feature:
- Macro BTB_SCHED_STATS_EN.
- When defined, adds three counters, reset to 0 by rst_n, each saturating at all-ones:
  - stat_installs (16 bits): count of FIFO writes with valid=1.
  - stat_invals (16 bits): count of FIFO writes with valid=0.
  - stat_flushes (8 bits): count of completed sweeps, incremented in DONE.
- When not defined, the stat_* ports still exist and are tied to 0, with no counter logic.

Test Plan:
- Reset then single install: upd_valid=1, upd_pc=0x0040_0010, target=0x0040_0100 at cycle 0 → cycle 1: btb_we=1, btb_idx=0x04, btb_wdata=0x1_0040_0100; cycle 2: btb_we=0.
- Back-to-back: 5 pushes in 5 consecutive cycles, depth 4, no flush → 5 writes in order on cycles 1–5, upd_ready stays 1, upd_ovf=0.
- Overflow: push 4 entries while in FLUSH, then a fifth → fifth dropped, upd_ready=0, upd_ovf=1 sticky; after DONE the 4 entries write in order.
- Flush: 2 entries queued, flush_req pulse → both discarded; 256 cycles btb_we=1 with idx 0..255 and wdata=0; flush_done pulse on cycle 257; pred_en=0 across all 257 cycles.
- Same-cycle push + flush_req → pushed entry written on first IDLE cycle after DONE; flush_req held high through DONE → second sweep starts immediately after.
- rst_n low at sweep index 100 → all outputs return to reset values asynchronously; after release, state IDLE and an invalidate of PC 0x0000_0008 writes idx 2, wdata 0.
